// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-destination output packet buffer of the 1x3 router
// Optional sticky ovf_err/udf_err flags are built when ROUTER_FIFO_ERR_EN is defined.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
`ifdef ROUTER_FIFO_ERR_EN
  ,
  output logic             ovf_err,
  output logic             udf_err
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH:0] mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [6:0]     pkt_cnt;
  logic           do_wr;
  logic           do_rd;
  logic [WIDTH:0] rd_entry;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  // soft_reset wins over both ports, so neither pointer may move in a flush cycle
  assign do_wr    = write_enb && !full && !soft_reset;
  assign do_rd    = read_enb && !empty && !soft_reset;
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_rd) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Header bits [7:2] carry payload length; the +1 accounts for the parity byte
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt <= '0;
    end else if (soft_reset) begin
      pkt_cnt <= '0;
    end else if (do_rd) begin
      if (rd_entry[WIDTH]) begin
        pkt_cnt <= {1'b0, rd_entry[7:2]} + 7'd1;
      end else if (pkt_cnt != 7'd0) begin
        pkt_cnt <= pkt_cnt - 7'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_out <= '0;
    end else if (soft_reset) begin
      data_out <= '0;
    end else if (do_rd) begin
      data_out <= rd_entry[WIDTH-1:0];
    end else if (pkt_cnt == 7'd0) begin
      data_out <= '0;
    end
  end

`ifdef ROUTER_FIFO_ERR_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else if (soft_reset) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (write_enb && full) ovf_err <= 1'b1;
      if (read_enb && empty) udf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - self-checking bench for router_fifo (table, directed and random vs queue model)
// Error-flag checks are compiled in when ROUTER_FIFO_ERR_EN is defined.
module tb_router_fifo;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
`ifdef ROUTER_FIFO_ERR_EN
  logic       ovf_err;
  logic       udf_err;
`endif

  router_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
`ifdef ROUTER_FIFO_ERR_EN
    ,
    .ovf_err    (ovf_err),
    .udf_err    (udf_err)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Reference model: a queue of {tag, byte} plus packet bookkeeping
  logic [8:0] q[$];
  int         m_pkt;
  logic [7:0] m_dout;
  bit         m_ovf;
  bit         m_udf;

  typedef struct {
    bit         sr;
    bit         wr;
    bit         rd;
    bit         lfd;
    logic [7:0] din;
    logic [7:0] dout;
    bit         f;
    bit         e;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit sr, input bit wr, input bit rd, input bit lfd, input logic [7:0] din);
    logic [8:0] e;
    bit was_full;
    bit was_empty;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (sr) begin
      q.delete();
      m_pkt  = 0;
      m_dout = 8'h00;
      m_ovf  = 0;
      m_udf  = 0;
    end else begin
      if (wr && was_full) m_ovf = 1;
      if (rd && was_empty) m_udf = 1;
      if (rd && !was_empty) begin
        e = q.pop_front();
        m_dout = e[7:0];
        if (e[8]) m_pkt = int'(e[7:2]) + 1;
        else if (m_pkt > 0) m_pkt = m_pkt - 1;
      end else if (m_pkt == 0) begin
        m_dout = 8'h00;
      end
      if (wr && !was_full) q.push_back({lfd, din});
    end
  endtask

  task automatic cycle(input bit sr, input bit wr, input bit rd, input bit lfd, input logic [7:0] din);
    soft_reset = sr;
    write_enb  = wr;
    read_enb   = rd;
    lfd_state  = lfd;
    data_in    = din;
    @(posedge clock);
    model_step(sr, wr, rd, lfd, din);
    @(negedge clock);
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    chk("model_dout", {24'h0, data_out}, {24'h0, m_dout});
    chk("model_full", {31'h0, full}, {31'h0, q.size() == DEPTH});
    chk("model_empty", {31'h0, empty}, {31'h0, q.size() == 0});
`ifdef ROUTER_FIFO_ERR_EN
    chk("model_ovf", {31'h0, ovf_err}, {31'h0, m_ovf});
    chk("model_udf", {31'h0, udf_err}, {31'h0, m_udf});
`endif
  endtask

  // Called with clock low; checks the asynchronous effect before any clock edge
  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk("rst_empty", {31'h0, empty}, 32'd1);
    chk("rst_full", {31'h0, full}, 32'd0);
    chk("rst_dout", {24'h0, data_out}, 32'd0);
`ifdef ROUTER_FIFO_ERR_EN
    chk("rst_ovf", {31'h0, ovf_err}, 32'd0);
    chk("rst_udf", {31'h0, udf_err}, 32'd0);
`endif
    q.delete();
    m_pkt  = 0;
    m_dout = 8'h00;
    m_ovf  = 0;
    m_udf  = 0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    bit full_seen;
    int wp;
    int rp;

    //          sr wr rd lfd din    dout   f  e
    tbl[0]  = '{0, 1, 0, 1, 8'h0E, 8'h00, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 8'hA1, 8'h00, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 8'hA2, 8'h00, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 8'hA3, 8'h00, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 8'h5C, 8'h00, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 8'h00, 8'h0E, 0, 0};
    tbl[6]  = '{0, 0, 1, 0, 8'h00, 8'hA1, 0, 0};
    tbl[7]  = '{0, 0, 1, 0, 8'h00, 8'hA2, 0, 0};
    tbl[8]  = '{0, 0, 1, 0, 8'h00, 8'hA3, 0, 0};
    tbl[9]  = '{0, 0, 1, 0, 8'h00, 8'h5C, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 1};
    tbl[11] = '{0, 1, 1, 1, 8'h04, 8'h00, 0, 0};
    tbl[12] = '{1, 0, 1, 0, 8'h00, 8'h00, 0, 1};

    #2;
    do_reset();

    // Packet drain, write+read on empty, and a flush overriding a read
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].sr, tbl[i].wr, tbl[i].rd, tbl[i].lfd, tbl[i].din);
      chk($sformatf("tbl%0d_dout", i), {24'h0, data_out}, {24'h0, tbl[i].dout});
      chk($sformatf("tbl%0d_full", i), {31'h0, full}, {31'h0, tbl[i].f});
      chk($sformatf("tbl%0d_empty", i), {31'h0, empty}, {31'h0, tbl[i].e});
    end

    // Fill to full, overflow attempt, then simultaneous write+read while full
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 1, 0, 0, 8'(i));
      if (i == 15) chk("full_before_16", {31'h0, full}, 32'd0);
    end
    chk("full_after_16", {31'h0, full}, 32'd1);
    cycle(0, 1, 0, 0, 8'hFF);
    chk("full_after_17", {31'h0, full}, 32'd1);
`ifdef ROUTER_FIFO_ERR_EN
    chk("ovf_set", {31'h0, ovf_err}, 32'd1);
`endif
    cycle(0, 1, 1, 0, 8'h77);
    chk("simul_dout", {24'h0, data_out}, 32'h01);
    chk("simul_full", {31'h0, full}, 32'd0);
    for (int i = 2; i <= 16; i++) begin
      cycle(0, 0, 1, 0, 8'h00);
      chk($sformatf("drain%0d", i), {24'h0, data_out}, i);
    end
    chk("drain_empty", {31'h0, empty}, 32'd1);
    cycle(0, 0, 0, 0, 8'h00);
    chk("drain_idle", {24'h0, data_out}, 32'd0);

    // Wrap-around without ever reaching full
    do_reset();
    full_seen = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, 0, 0, 8'(8'h30 + i));
      full_seen |= full;
    end
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 1, 0, 8'h00);
      chk($sformatf("wrapA%0d", i), {24'h0, data_out}, 32'h30 + i);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 0, 8'(8'h20 + i));
      full_seen |= full;
    end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 0, 8'h00);
      chk($sformatf("wrapB%0d", i), {24'h0, data_out}, 32'h20 + i);
    end
    chk("wrap_full_never", {31'h0, full_seen}, 32'd0);

    // Soft reset after 3 bytes of a 6-byte packet
    cycle(0, 1, 0, 1, 8'h10);
    for (int i = 1; i <= 5; i++) cycle(0, 1, 0, 0, 8'(8'hB0 + i));
    cycle(0, 0, 1, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'h00);
    chk("sr_third", {24'h0, data_out}, 32'hB2);
    cycle(0, 0, 0, 0, 8'h00);
    chk("sr_hold", {24'h0, data_out}, 32'hB2);
    cycle(1, 0, 0, 0, 8'h00);
    chk("sr_dout", {24'h0, data_out}, 32'd0);
    chk("sr_empty", {31'h0, empty}, 32'd1);
    cycle(0, 1, 0, 1, 8'h09);
    cycle(0, 1, 0, 0, 8'hC1);
    cycle(0, 1, 0, 0, 8'hC2);
    cycle(0, 1, 0, 0, 8'hC3);
    cycle(0, 0, 1, 0, 8'h00);
    chk("new_hdr", {24'h0, data_out}, 32'h09);
    cycle(0, 0, 1, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'h00);
    chk("new_parity", {24'h0, data_out}, 32'hC3);
    cycle(0, 0, 0, 0, 8'h00);
    chk("new_idle", {24'h0, data_out}, 32'd0);

    // Read while empty
    cycle(0, 0, 1, 0, 8'h00);
    chk("udr_dout", {24'h0, data_out}, 32'd0);
    chk("udr_empty", {31'h0, empty}, 32'd1);
`ifdef ROUTER_FIFO_ERR_EN
    chk("udf_set", {31'h0, udf_err}, 32'd1);
`endif
    cycle(1, 0, 0, 0, 8'h00);
`ifdef ROUTER_FIFO_ERR_EN
    chk("udf_cleared", {31'h0, udf_err}, 32'd0);
`endif

    // Random traffic in three load phases against the model
    for (int ph = 0; ph < 3; ph++) begin
      wp = 70 - 20 * ph;
      rp = 30 + 20 * ph;
      for (int n = 0; n < 700; n++) begin
        cycle($urandom_range(99) < 1, $urandom_range(99) < wp, $urandom_range(99) < rp,
              $urandom_range(5) == 0, 8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
